// File: rtl/NVM_pkg.sv
// Shared types for the GC responder: FSM states, block address type and
// the default clean-block threshold.
package NVM_pkg;

    localparam int unsigned BLK_ADDR_W       = 10;
    localparam int unsigned GC_THRESHOLD_DEF = 2;

    typedef logic [BLK_ADDR_W-1:0] blk_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_READY,
        ST_MOVE,
        ST_ERASE
    } gc_state_e;

endpackage

// File: rtl/clean_blk_fifo.sv
// FIFO of clean block addresses: push/pop/flush with occupancy count,
// registered pop data and a sticky overflow flag for dropped pushes.
module clean_blk_fifo
    import NVM_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  blk_addr_t        push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_nxt_c,
    output blk_addr_t        pop_data_o,
    output logic             pop_valid_o,
    output logic             overflow_o
);

    // One slot is never used so the count always fits in CNT_W bits.
    localparam int unsigned SLOTS = 2 ** CNT_W;
    localparam int unsigned DEPTH = SLOTS - 1;

    blk_addr_t        mem_q [SLOTS];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop_valid_q;
    blk_addr_t        pop_data_q;
    logic             full, empty, do_push, do_pop;

    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        empty      = (count_q == '0);
        do_pop     = pop_i && !empty && !flush_i;
        do_push    = push_i && !flush_i && (!full || do_pop);
        wr_ptr_d   = wr_ptr_q + CNT_W'(do_push);
        rd_ptr_d   = rd_ptr_q + CNT_W'(do_pop);
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        overflow_d = overflow_q || (push_i && full && !do_pop);
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            pop_valid_q <= do_pop;
            if (do_pop) begin
                pop_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign count_o     = count_q;
    assign count_nxt_c = count_d;
    assign pop_data_o  = pop_data_q;
    assign pop_valid_o = pop_valid_q;
    assign overflow_o  = overflow_q;

endmodule

// File: rtl/gc_clean_fifo_resp.sv
// GC responder: owns the clean-block FIFO and runs the page-move and
// block-erase handshakes requested by the GC controller.
module gc_clean_fifo_resp
    import NVM_pkg::*;
#(
    parameter int unsigned FIFO_SIZE_BIT_NUM = 4,
    parameter int unsigned PAGES_PER_BLK     = 64,
    parameter int unsigned GC_THRESHOLD      = GC_THRESHOLD_DEF
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               initial_fifo,
    input  logic                               ini_blk_valid,
    input  blk_addr_t                          ini_blk_addr,
    input  logic                               request_blk_clean,
    input  logic                               move_flag,
    input  logic                               gc_request,
    input  blk_addr_t                          victim_blk_addr,
    input  logic                               req_done,
    input  logic                               gc_interrupt,
    input  logic                               copy_ack,
    input  logic                               erase_ack,
    output logic                               gc_ini,
    output logic                               gc_start,
    output logic                               move_done_flag,
    output logic                               fifo_recover_en,
    output logic [FIFO_SIZE_BIT_NUM-1:0]       clean_num,
    output logic                               ini_full,
    output blk_addr_t                          clean_blk_addr,
    output logic                               clean_blk_valid,
    output logic                               copy_req,
    output logic                               erase_req,
    output blk_addr_t                          erase_blk_addr,
    output logic [$clog2(PAGES_PER_BLK)-1:0]   page_idx,
    output logic                               overflow
);

    localparam int unsigned PAGE_W = $clog2(PAGES_PER_BLK);
    localparam int unsigned DEPTH  = (2 ** FIFO_SIZE_BIT_NUM) - 1;

    gc_state_e             state_q, state_d;
    logic                  copy_req_q, copy_req_d;
    logic                  erase_req_q, erase_req_d;
    blk_addr_t             erase_addr_q, erase_addr_d;
    blk_addr_t             victim_q, victim_d;
    logic [PAGE_W-1:0]     page_q, page_d;
    logic                  move_done_q, move_done_d;
    logic                  recover_q, recover_d;
    logic                  gc_ini_q, gc_ini_d;
    logic                  ini_full_q, ini_full_d;
    logic                  gc_start_q, gc_start_d;
    logic                  pending_q, pending_d;
    logic                  intr_q, intr_d;

    logic                          flush_c, push_c, pop_c;
    blk_addr_t                     push_data_c;
    logic [FIFO_SIZE_BIT_NUM-1:0]  count_nxt_c;

    clean_blk_fifo #(.CNT_W(FIFO_SIZE_BIT_NUM)) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .flush_i     (flush_c),
        .push_i      (push_c),
        .push_data_i (push_data_c),
        .pop_i       (pop_c),
        .count_o     (clean_num),
        .count_nxt_c (count_nxt_c),
        .pop_data_o  (clean_blk_addr),
        .pop_valid_o (clean_blk_valid),
        .overflow_o  (overflow)
    );

    always_comb begin
        state_d      = state_q;
        copy_req_d   = copy_req_q;
        erase_req_d  = erase_req_q;
        erase_addr_d = erase_addr_q;
        victim_d     = victim_q;
        page_d       = page_q;
        move_done_d  = 1'b0;
        recover_d    = 1'b0;
        gc_ini_d     = 1'b0;
        ini_full_d   = ini_full_q;
        pending_d    = pending_q;
        intr_d       = intr_q;
        flush_c      = 1'b0;
        push_c       = 1'b0;
        push_data_c  = ini_blk_addr;
        pop_c        = 1'b0;

        if (initial_fifo) begin
            flush_c     = 1'b1;
            ini_full_d  = 1'b0;
            copy_req_d  = 1'b0;
            erase_req_d = 1'b0;
            pending_d   = 1'b0;
            intr_d      = 1'b0;
            state_d     = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (ini_blk_valid) begin
                        push_c = 1'b1;
                        if (clean_num == FIFO_SIZE_BIT_NUM'(DEPTH - 1)) begin
                            ini_full_d = 1'b1;
                            gc_ini_d   = 1'b1;
                            state_d    = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    pop_c = request_blk_clean;
                    if (gc_request) begin
                        victim_d = victim_blk_addr;
                    end
                    // A move outranks an erase; a coincident req_done waits.
                    if (move_flag) begin
                        copy_req_d = 1'b1;
                        pending_d  = pending_q || req_done;
                        intr_d     = 1'b0;
                        state_d    = ST_MOVE;
                    end else if (req_done || pending_q) begin
                        erase_req_d  = 1'b1;
                        erase_addr_d = victim_q;
                        pending_d    = 1'b0;
                        state_d      = ST_ERASE;
                    end
                end
                ST_MOVE: begin
                    pop_c = request_blk_clean;
                    if (gc_request) begin
                        victim_d = victim_blk_addr;
                    end
                    if (req_done) begin
                        pending_d = 1'b1;
                    end
                    if (gc_interrupt) begin
                        intr_d = 1'b1;
                    end
                    // An aborted copy still waits for the NAND ack but is not counted.
                    if (copy_ack) begin
                        copy_req_d = 1'b0;
                        intr_d     = 1'b0;
                        state_d    = ST_READY;
                        if (!intr_q && !gc_interrupt) begin
                            move_done_d = 1'b1;
                            page_d = (page_q == PAGE_W'(PAGES_PER_BLK - 1)) ? '0 : page_q + 1'b1;
                        end
                    end
                end
                ST_ERASE: begin
                    pop_c = request_blk_clean;
                    if (erase_ack) begin
                        push_c      = 1'b1;
                        push_data_c = erase_addr_q;
                        recover_d   = 1'b1;
                        page_d      = '0;
                        erase_req_d = 1'b0;
                        state_d     = ST_READY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gc_start_d = (count_nxt_c <= FIFO_SIZE_BIT_NUM'(GC_THRESHOLD)) &&
                        (state_d inside {ST_READY, ST_MOVE, ST_ERASE});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            copy_req_q   <= 1'b0;
            erase_req_q  <= 1'b0;
            erase_addr_q <= '0;
            victim_q     <= '0;
            page_q       <= '0;
            move_done_q  <= 1'b0;
            recover_q    <= 1'b0;
            gc_ini_q     <= 1'b0;
            ini_full_q   <= 1'b0;
            gc_start_q   <= 1'b0;
            pending_q    <= 1'b0;
            intr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            copy_req_q   <= copy_req_d;
            erase_req_q  <= erase_req_d;
            erase_addr_q <= erase_addr_d;
            victim_q     <= victim_d;
            page_q       <= page_d;
            move_done_q  <= move_done_d;
            recover_q    <= recover_d;
            gc_ini_q     <= gc_ini_d;
            ini_full_q   <= ini_full_d;
            gc_start_q   <= gc_start_d;
            pending_q    <= pending_d;
            intr_q       <= intr_d;
        end
    end

    assign gc_ini          = gc_ini_q;
    assign gc_start        = gc_start_q;
    assign move_done_flag  = move_done_q;
    assign fifo_recover_en = recover_q;
    assign ini_full        = ini_full_q;
    assign copy_req        = copy_req_q;
    assign erase_req       = erase_req_q;
    assign erase_blk_addr  = erase_addr_q;
    assign page_idx        = page_q;

endmodule

// File: doc/gc_clean_fifo_resp.md
Name: gc_clean_fifo_resp

Overview:
- Responder end of the garbage-collection controller interface. Owns the FIFO of clean NAND block addresses and reports its occupancy (clean_num, ini_full, gc_start).
- Executes the page-move and block-erase handshakes that the GC controller initiates (move_flag, req_done), and recycles erased victim blocks back into the FIFO (fifo_recover_en).
- Sits between the GC controller and the NAND command layer in the NVM top level.

Parameters:
FIFO_SIZE_BIT_NUM, 4, clean_num width; FIFO capacity DEPTH = 2**FIFO_SIZE_BIT_NUM - 1 (15), so clean_num never overflows its width
BLK_ADDR_W, 10, NAND block address width
PAGES_PER_BLK, 64, pages per block; page_idx wraps at this value
GC_THRESHOLD, 2, gc_start asserted while clean_num <= this value

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
initial_fifo  in  1  one-cycle pulse: flush FIFO and start initial fill
ini_blk_valid  in  1  initial-fill address valid
ini_blk_addr  in  BLK_ADDR_W  initial-fill block address
request_blk_clean  in  1  one-cycle pop request for a clean block
move_flag  in  1  one-cycle pulse: copy one valid page
gc_request  in  1  one-cycle pulse: latch victim_blk_addr
victim_blk_addr  in  BLK_ADDR_W  victim block selected by GC
req_done  in  1  one-cycle pulse: victim fully moved, erase it
gc_interrupt  in  1  abort the current move
copy_ack  in  1  NAND copy complete
erase_ack  in  1  NAND erase complete
gc_ini  out  1  one-cycle pulse on initial-fill completion
gc_start  out  1  low-clean-block level
move_done_flag  out  1  one-cycle pulse: page move finished
fifo_recover_en  out  1  one-cycle pulse: victim pushed back into FIFO
clean_num  out  FIFO_SIZE_BIT_NUM  current FIFO occupancy
ini_full  out  1  level: initial fill complete
clean_blk_addr  out  BLK_ADDR_W  popped block address
clean_blk_valid  out  1  one-cycle pulse qualifying clean_blk_addr
copy_req  out  1  NAND copy request, held until copy_ack
erase_req  out  1  NAND erase request, held until erase_ack
erase_blk_addr  out  BLK_ADDR_W  block to erase (latched victim address)
page_idx  out  log2(PAGES_PER_BLK)  victim page being moved
overflow  out  1  sticky flag: a push was dropped because the FIFO was full

Behaviour:
- Reset (any time, including mid-operation): state IDLE; FIFO pointers, clean_num, page_idx, latched victim and every output are 0; in-flight copy_req/erase_req are dropped.
- States: IDLE, INIT, READY, MOVE, ERASE.
- initial_fifo in any state: flush FIFO, clear ini_full, go to INIT. Highest priority after reset.
- INIT: each ini_blk_valid cycle pushes ini_blk_addr. On the push that makes clean_num == DEPTH: ini_full = 1, gc_ini pulses the next cycle, state goes to READY.
- READY: move_flag -> MOVE with copy_req = 1 the next cycle. req_done -> ERASE with erase_req = 1 the next cycle. If both arrive in the same cycle, move_flag wins and req_done is held pending until the move completes. gc_request latches victim_blk_addr in READY or MOVE.
- MOVE: copy_req stays high until copy_ack is seen. On copy_ack: copy_req = 0, move_done_flag pulses the same registered cycle, page_idx increments (wraps PAGES_PER_BLK-1 -> 0), return to READY.
- gc_interrupt in MOVE: no move_done_flag; copy_req is still held until copy_ack; then go to READY with page_idx unchanged.
- ERASE: erase_blk_addr = latched victim; erase_req stays high until erase_ack. On erase_ack: push victim, pulse fifo_recover_en, page_idx = 0, return to READY.
- Pop: request_blk_clean in READY/MOVE/ERASE with clean_num > 0 -> clean_blk_addr = head and clean_blk_valid pulses one cycle later. Pop on empty is ignored; no valid pulse.
- Push and pop in the same cycle: both happen and clean_num is unchanged.
- Push while full (clean_num == DEPTH, no same-cycle pop): the push is dropped and overflow is set (sticky until reset or initial_fifo). fifo_recover_en still pulses.
- gc_start = (clean_num <= GC_THRESHOLD) && state != IDLE && state != INIT. All outputs are registered.

Decomposition:
- NVM_pkg holds the state enum type, the blk_addr_t typedef (BLK_ADDR_W) and the default GC_THRESHOLD constant.
- Sub-module clean_blk_fifo holds storage, pointers and count: push, pop, flush, full/empty, same-cycle push/pop.
- The top level contains the FSM, page counter and handshakes.

Test Plan:
- Reset, initial_fifo, then 15 ini_blk_valid with addresses 1..15 -> ini_full = 1, gc_ini pulses exactly once, clean_num = 15, gc_start = 0.
- 13 request_blk_clean -> addresses 1..13 returned in order, clean_num = 2, gc_start = 1; 3 further pops -> 14, 15, then no valid pulse on the third.
- gc_request with victim 0x2A, move_flag, copy_ack after 5 cycles -> copy_req high for 5 cycles, one move_done_flag pulse, page_idx = 1; 64 moves total -> page_idx wraps to 0.
- req_done, erase_ack after 3 cycles -> erase_blk_addr = 0x2A, fifo_recover_en pulses, FIFO tail = 0x2A, clean_num increments.
- request_blk_clean in the same cycle as the erase_ack push, with clean_num = 15 -> clean_num stays 15, overflow = 0; repeat the erase with no pop at clean_num = 15 -> overflow = 1.
- gc_interrupt during MOVE -> no move_done_flag, page_idx unchanged; RST asserted mid-ERASE -> all outputs 0 immediately.
